// File: rtl/herring_gpu_pkg.sv
// rtl/herring_gpu_pkg.sv - shared text-mode geometry and arbiter state type.
// Optional VRAM_CLEAR_EN adds the CLEAR state.
package herring_gpu_pkg;
  localparam int TEXT_COLS    = 80;
  localparam int TEXT_ROWS    = 60;
  localparam int CELL_SHIFT   = 3;
  localparam int H_ACTIVE_END = 639;
  localparam int V_ACTIVE_END = 479;
  localparam int CELL_COUNT   = TEXT_COLS * TEXT_ROWS;

`ifdef VRAM_CLEAR_EN
  typedef enum logic [1:0] {IDLE, FETCH, WRITE, CLEAR} arb_state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, WRITE} arb_state_t;
`endif
endpackage

// File: rtl/vram_wr_fifo.sv
// rtl/vram_wr_fifo.sv - synchronous CPU write queue (address+data), power-of-two depth.
module vram_wr_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W+DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         count;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign {head_addr, head_data} = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Push on a full queue only happens alongside a pop, so it overwrites the slot being read out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_addr, push_data};
  end
endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter: character fetch slots beat queued CPU writes.
// Optional VRAM_CLEAR_EN zero-fills the text buffer after reset.
module vram_arbiter
  import herring_gpu_pkg::*;
#(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              PIXEL_CLOCK,
  input  logic              RESET_N,
  input  logic [9:0]        SCREEN_X,
  input  logic [9:0]        SCREEN_Y,
  input  logic              CPU_WR_REQ,
  input  logic [ADDR_W-1:0] CPU_WR_ADDR,
  input  logic [DATA_W-1:0] CPU_WR_DATA,
  output logic              CPU_WR_READY,
  output logic [ADDR_W-1:0] VRAM_ADDR,
  output logic [DATA_W-1:0] VRAM_WDATA,
  output logic              VRAM_WE,
  input  logic [DATA_W-1:0] VRAM_RDATA,
  output logic [DATA_W-1:0] FETCH_DATA,
  output logic              FETCH_VALID
);
  arb_state_t        state_q, state_d;
  logic              run_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] fetch_data_q;
  logic              fetch_valid_q;
  logic              fifo_full, fifo_empty, push, pop;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              slot;
  logic [6:0]        row;
  logic [ADDR_W-1:0] fetch_addr;

  assign slot = (SCREEN_X[2:0] == 3'd0) && (SCREEN_X <= 10'(H_ACTIVE_END))
             && (SCREEN_Y <= 10'(V_ACTIVE_END));
  assign row  = SCREEN_Y[9:CELL_SHIFT];
  // row*80 as row*64 + row*16
  assign fetch_addr = ADDR_W'({row, 6'b0}) + ADDR_W'({row, 4'b0}) + ADDR_W'(SCREEN_X[9:CELL_SHIFT]);

  assign push         = CPU_WR_REQ && CPU_WR_READY;
  assign CPU_WR_READY = run_q && (!fifo_full || pop);
  assign FETCH_DATA   = fetch_data_q;
  assign FETCH_VALID  = fetch_valid_q;

`ifdef VRAM_CLEAR_EN
  logic              clr_busy_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              clr_last;
  assign clr_last = (clr_cnt_q == ADDR_W'(CELL_COUNT - 1));
`endif

  always_comb begin
    state_d    = IDLE;
    pop        = 1'b0;
    VRAM_WE    = 1'b0;
    VRAM_ADDR  = addr_q;
    VRAM_WDATA = '0;
    if (slot) begin
      state_d   = FETCH;
      VRAM_ADDR = fetch_addr;
`ifdef VRAM_CLEAR_EN
    end else if (clr_busy_q) begin
      state_d   = CLEAR;
      VRAM_WE   = 1'b1;
      VRAM_ADDR = clr_cnt_q;
`endif
    end else if (!fifo_empty) begin
      state_d    = WRITE;
      pop        = 1'b1;
      VRAM_WE    = 1'b1;
      VRAM_ADDR  = head_addr;
      VRAM_WDATA = head_data;
    end
    // Reset must kill a write already being presented this cycle.
    if (!RESET_N) begin
      pop        = 1'b0;
      VRAM_WE    = 1'b0;
      VRAM_ADDR  = '0;
      VRAM_WDATA = '0;
    end
  end

  always_ff @(posedge PIXEL_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
`ifdef VRAM_CLEAR_EN
      state_q <= CLEAR;
`else
      state_q <= IDLE;
`endif
      run_q         <= 1'b0;
      addr_q        <= '0;
      fetch_data_q  <= '0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= VRAM_ADDR;
      fetch_valid_q <= (state_q == FETCH);
      if (state_q == FETCH) fetch_data_q <= VRAM_RDATA;
`ifdef VRAM_CLEAR_EN
      run_q <= !clr_busy_q || ((state_d == CLEAR) && clr_last);
`else
      run_q <= 1'b1;
`endif
    end
  end

`ifdef VRAM_CLEAR_EN
  always_ff @(posedge PIXEL_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      clr_busy_q <= 1'b1;
      clr_cnt_q  <= '0;
    end else if (state_d == CLEAR) begin
      clr_cnt_q <= clr_cnt_q + 1'b1;
      if (clr_last) clr_busy_q <= 1'b0;
    end
  end
`endif

  vram_wr_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wr_fifo (
    .clk       (PIXEL_CLOCK),
    .rst_n     (RESET_N),
    .push      (push),
    .push_addr (CPU_WR_ADDR),
    .push_data (CPU_WR_DATA),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_addr (head_addr),
    .head_data (head_data)
  );
endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - scoreboard bench for vram_arbiter; honours VRAM_CLEAR_EN.
`timescale 1ns/1ps
module tb_vram_arbiter;
  localparam int DEPTH = 4;
`ifdef VRAM_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  sx, sy;
  logic        req;
  logic [12:0] waddr;
  logic [7:0]  wdata;
  logic        ready;
  logic [12:0] vaddr;
  logic [7:0]  vwdata;
  logic        vwe;
  logic [7:0]  vrdata;
  logic [7:0]  fdata;
  logic        fvalid;
  logic [12:0] vram_last;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(13), .DATA_W(8), .FIFO_DEPTH(DEPTH)) dut (
    .PIXEL_CLOCK (clk),
    .RESET_N     (rst_n),
    .SCREEN_X    (sx),
    .SCREEN_Y    (sy),
    .CPU_WR_REQ  (req),
    .CPU_WR_ADDR (waddr),
    .CPU_WR_DATA (wdata),
    .CPU_WR_READY(ready),
    .VRAM_ADDR   (vaddr),
    .VRAM_WDATA  (vwdata),
    .VRAM_WE     (vwe),
    .VRAM_RDATA  (vrdata),
    .FETCH_DATA  (fdata),
    .FETCH_VALID (fvalid)
  );

  // VRAM stand-in: read data one cycle later is a fixed function of the address (82 -> 0x41).
  always @(posedge clk) vram_last <= vaddr;
  assign vrdata = vram_last[7:0] ^ 8'h13;

  typedef struct { logic [12:0] addr; logic [7:0] data; } wr_t;
  typedef struct { int cyc; logic [7:0] data; } fe_t;
  typedef struct { bit rstn; bit we; bit ready; logic [12:0] addr; } cy_t;

  wr_t mdl_fifo[$];
  wr_t wr_q[$];
  fe_t fe_q[$];
  cy_t cy_q[$];

  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  bit          run = 1'b0;
  bit          clr_busy = CLR_EN;
  int          clr_idx = 0;
  logic [12:0] model_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // One clock of stimulus; pushes this cycle's expectations from the reference model.
  task automatic step(input logic [9:0] x, input logic [9:0] y, input bit rq,
                      input logic [12:0] a, input logic [7:0] d, input bit rn, output bit acc);
    bit          slot, pop;
    cy_t         r;
    wr_t         e;
    fe_t         f;
    logic [12:0] fa;
    sx = x; sy = y; req = rq; waddr = a; wdata = d; rst_n = rn;
    acc = 1'b0;
    r.rstn = rn; r.we = 1'b0; r.ready = 1'b0; r.addr = '0;
    if (!rn) begin
      mdl_fifo.delete(); wr_q.delete(); fe_q.delete();
      run = 1'b0; clr_busy = CLR_EN; clr_idx = 0; model_addr = '0;
    end else begin
      slot = (x % 8 == 0) && (x < 640) && (y < 480);
      fa   = 13'((y / 8) * 80 + x / 8);
      pop  = !slot && !clr_busy && (mdl_fifo.size() > 0);
      r.ready = run && !clr_busy && ((mdl_fifo.size() < DEPTH) || pop);
      acc = rq && r.ready;
      if (slot) begin
        model_addr = fa;
        f.cyc = cyc + 2; f.data = fa[7:0] ^ 8'h13;
        fe_q.push_back(f);
      end else if (clr_busy) begin
        model_addr = 13'(clr_idx);
        r.we = 1'b1;
        e.addr = 13'(clr_idx); e.data = 8'h00;
        wr_q.push_back(e);
        clr_idx++;
        if (clr_idx == 4800) clr_busy = 1'b0;
      end else if (pop) begin
        e = mdl_fifo.pop_front();
        model_addr = e.addr;
        r.we = 1'b1;
        wr_q.push_back(e);
      end
      r.addr = model_addr;
      if (acc) begin
        e.addr = a; e.data = d;
        mdl_fifo.push_back(e);
      end
      if (!clr_busy) run = 1'b1;
    end
    cy_q.push_back(r);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  always @(negedge clk) begin
    cy_t r;
    wr_t e;
    fe_t f;
    if (cy_q.size() > 0) begin
      r = cy_q.pop_front();
      if (!r.rstn) begin
        chk("rst_we", vwe, 0);
        chk("rst_addr", vaddr, 0);
        chk("rst_wdata", vwdata, 0);
        chk("rst_ready", ready, 0);
        chk("rst_fvalid", fvalid, 0);
        chk("rst_fdata", fdata, 0);
      end else begin
        chk("ready", ready, r.ready);
        chk("we", vwe, r.we);
        chk("addr", vaddr, r.addr);
        if (r.we) begin
          e = wr_q.pop_front();
          if (vwe) chk("wdata", vwdata, e.data);
        end
        if (fvalid) begin
          if (fe_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL fetch_unexpected cyc=%0d actual=valid required=none", cyc);
          end else begin
            f = fe_q.pop_front();
            chk("fetch_cycle", cyc, f.cyc);
            chk("fetch_data", fdata, f.data);
          end
        end else if (fe_q.size() > 0 && fe_q[0].cyc <= cyc) begin
          f = fe_q.pop_front();
          checks++; errors++;
          $display("FAIL fetch_missing cyc=%0d actual=none required=cycle %0d", cyc, f.cyc);
        end
      end
    end
  end

  initial begin
    bit          acc;
    logic [9:0]  x, y;
    int          pin;
    rst_n = 1'b0; sx = '0; sy = '0; req = 1'b0; waddr = '0; wdata = '0;
    @(posedge clk); #1;
    repeat (3) step(10'd640, 10'd0, 1'b0, 13'd0, 8'd0, 1'b0, acc);

    // Clear sweep (only in the VRAM_CLEAR_EN build), fetches interleaved
    for (int n = 0; n < 8000 && clr_busy; n++)
      step(10'(n % 800), 10'd472, 1'b0, 13'd0, 8'd0, 1'b1, acc);
    step(10'd641, 10'd0, 1'b0, 13'd0, 8'd0, 1'b1, acc);

    // Fetch at X=16,Y=8 -> address 82, data 0x41 two cycles later
    for (int i = 16; i < 20; i++) step(10'(i), 10'd8, 1'b0, 13'd0, 8'd0, 1'b1, acc);

    // Write queued at X=7, blocked by slot at X=8, issued at X=9
    step(10'd7, 10'd0, 1'b1, 13'h0010, 8'h55, 1'b1, acc);
    for (int i = 8; i < 12; i++) step(10'(i), 10'd0, 1'b0, 13'd0, 8'd0, 1'b1, acc);

    // Fill to depth while the slot is held, 5th waits for READY, then drain in blanking
    for (int i = 0; i < 4; i++) step(10'd0, 10'd0, 1'b1, 13'(100 + i), 8'(8'hA0 + i), 1'b1, acc);
    repeat (2) step(10'd0, 10'd0, 1'b1, 13'd104, 8'hA4, 1'b1, acc);
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) step(10'(640 + k), 10'd0, 1'b1, 13'd104, 8'hA4, 1'b1, acc);
    for (int k = 0; k < 8; k++) step(10'(660 + k), 10'd0, 1'b0, 13'd0, 8'd0, 1'b1, acc);

    // Full queue with push and pop together at X=700
    for (int i = 0; i < 4; i++) step(10'd8, 10'd16, 1'b1, 13'(200 + i), 8'(8'hB0 + i), 1'b1, acc);
    for (int k = 0; k < 3; k++) step(10'(700 + k), 10'd16, 1'b1, 13'(204 + k), 8'(8'hB4 + k), 1'b1, acc);
    for (int k = 0; k < 8; k++) step(10'(710 + k), 10'd16, 1'b0, 13'd0, 8'd0, 1'b1, acc);

    // Random raster traffic with occasional held slots to back the queue up
    x = 10'($urandom_range(0, 799)); y = 10'($urandom_range(0, 524)); pin = 0;
    for (int i = 0; i < 3000; i++) begin
      step(x, y, ($urandom_range(0, 3) != 0), 13'($urandom_range(0, 4799)), 8'($urandom), 1'b1, acc);
      if (pin > 0) pin--;
      else if (x % 8 == 0 && x < 640 && $urandom_range(0, 7) == 0) pin = $urandom_range(1, 6);
      else begin
        x = (x == 10'd799) ? 10'd0 : x + 10'd1;
        if (x == 10'd0) y = (y == 10'd524) ? 10'd0 : y + 10'd1;
        if ($urandom_range(0, 255) == 0) y = 10'($urandom_range(0, 524));
      end
    end
    for (int k = 0; k < 8; k++) step(10'(640 + k), 10'd500, 1'b0, 13'd0, 8'd0, 1'b1, acc);

    // Reset with three writes queued: nothing from them may land afterwards
    for (int i = 0; i < 3; i++) step(10'd0, 10'd0, 1'b1, 13'(300 + i), 8'(8'hC0 + i), 1'b1, acc);
    repeat (2) step(10'd640, 10'd0, 1'b0, 13'd0, 8'd0, 1'b0, acc);
    for (int k = 0; k < 12; k++) step(10'(641 + k), 10'd0, 1'b0, 13'd0, 8'd0, 1'b1, acc);

    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
